// File: rtl/contador_cascada_pkg.sv
// Shared definitions for the cascaded up/down counter: operation codes and slice width.
// Bench and RTL both import this so the model and the design agree on encodings.
package contador_cascada_pkg;

  localparam int NIB_W = 4;

  localparam logic [1:0] MODO_UP1  = 2'b00;
  localparam logic [1:0] MODO_DN1  = 2'b01;
  localparam logic [1:0] MODO_UP3  = 2'b10;
  localparam logic [1:0] MODO_LOAD = 2'b11;

endpackage

// File: rtl/contador_nibble.sv
// One 4-bit counter slice: adds or subtracts its increment (step of 3 or the incoming
// carry/borrow), loads d on ld, and exposes the carry/borrow out combinationally.
import contador_cascada_pkg::*;

module contador_nibble (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_en,
  input  logic             dir,
  input  logic             step3,
  input  logic             cin,
  input  logic             ld,
  input  logic [NIB_W-1:0] d,
  output logic [NIB_W-1:0] q,
  output logic             cout
);

  logic [NIB_W-1:0] inc;
  logic [NIB_W:0]   nxt;

  // The extra MSB of nxt is the carry (up) or borrow (down) out of this slice.
  always_comb begin
    inc = step3 ? NIB_W'(3) : {{(NIB_W-1){1'b0}}, cin};
    if (dir) nxt = {1'b0, q} - {1'b0, inc};
    else     nxt = {1'b0, q} + {1'b0, inc};
    cout = step_en & nxt[NIB_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        q <= '0;
    else if (ld)      q <= d;
    else if (step_en) q <= nxt[NIB_W-1:0];
  end

endmodule

// File: rtl/contador_cascada.sv
// Multi-mode up/down counter built from NIB cascaded 4-bit slices; rco is the
// registered carry/borrow out of the top slice.
import contador_cascada_pkg::*;

module contador_cascada #(
  parameter  int NIB = 1,
  localparam int W   = 4 * NIB
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [1:0]   modo,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q,
  output logic         rco
);

  logic         step_en;
  logic         ld;
  logic         dir;
  logic         up3;
  logic [NIB:0] carry;
  logic [W-1:0] q_all;

  always_comb begin
    step_en = enable && (modo != MODO_LOAD);
    ld      = enable && (modo == MODO_LOAD);
    dir     = (modo == MODO_DN1);
    up3     = (modo == MODO_UP3);
  end

  // Stage 0 always sees cin=1 so it applies the +/-1 step; higher stages only ripple.
  assign carry[0] = 1'b1;

  for (genvar k = 0; k < NIB; k++) begin : g_nib
    contador_nibble u_nib (
      .clk     (clk),
      .reset   (reset),
      .step_en (step_en),
      .dir     (dir),
      .step3   ((k == 0) ? up3 : 1'b0),
      .cin     (carry[k]),
      .ld      (ld),
      .d       (D[NIB_W*k +: NIB_W]),
      .q       (q_all[NIB_W*k +: NIB_W]),
      .cout    (carry[k+1])
    );
  end

  assign Q = q_all;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rco <= 1'b0;
    else       rco <= carry[NIB];
  end

endmodule

// File: tb/tb_contador_cascada.sv
// Scoreboard bench for contador_cascada: a 4-bit (NIB=1) and an 8-bit (NIB=2) instance,
// directed vectors with hand-computed results plus a short modelled random run.
import contador_cascada_pkg::*;

module tb_contador_cascada;

  typedef struct {
    string      name;
    logic [7:0] q;
    logic       rco;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en1 = 1'b0, en2 = 1'b0;
  logic [1:0] modo1 = MODO_UP1, modo2 = MODO_UP1;
  logic [3:0] d1 = '0;
  logic [7:0] d2 = '0;
  logic [3:0] q1;
  logic [7:0] q2;
  logic       rco1, rco2;

  exp_t sb1[$];
  exp_t sb2[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] cur2 = '0;

  always #5 clk = ~clk;

  contador_cascada #(.NIB(1)) dut1 (
    .clk(clk), .reset(reset), .enable(en1), .modo(modo1), .D(d1), .Q(q1), .rco(rco1));
  contador_cascada #(.NIB(2)) dut2 (
    .clk(clk), .reset(reset), .enable(en2), .modo(modo2), .D(d2), .Q(q2), .rco(rco2));

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input logic en, input logic [1:0] m, input logic [7:0] d,
                                input logic [7:0] q, output logic [7:0] nq, output logic nr);
    logic [8:0] s;
    nq = q;
    nr = 1'b0;
    if (en) begin
      case (m)
        MODO_UP1: begin s = {1'b0, q} + 9'd1; nq = s[7:0]; nr = s[8]; end
        MODO_DN1: begin s = {1'b0, q} - 9'd1; nq = s[7:0]; nr = s[8]; end
        MODO_UP3: begin s = {1'b0, q} + 9'd3; nq = s[7:0]; nr = s[8]; end
        default:  begin nq = d; nr = 1'b0; end
      endcase
    end
  endfunction

  task automatic step1(input string name, input logic en, input logic [1:0] m,
                       input logic [3:0] d, input logic [3:0] eq, input logic er);
    exp_t e;
    @(negedge clk);
    en1 = en; modo1 = m; d1 = d;
    e.name = name; e.q = {4'h0, eq}; e.rco = er;
    sb1.push_back(e);
  endtask

  task automatic step2(input string name, input logic en, input logic [1:0] m,
                       input logic [7:0] d, input logic [7:0] eq, input logic er);
    exp_t e;
    @(negedge clk);
    en2 = en; modo2 = m; d2 = d;
    e.name = name; e.q = eq; e.rco = er;
    sb2.push_back(e);
    cur2 = eq;
  endtask

  // Monitor: every output observed after an edge is matched to the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb1.size() > 0) begin
        e = sb1.pop_front();
        chk({e.name, ".q"}, {4'h0, q1}, e.q);
        chk({e.name, ".rco"}, {7'h0, rco1}, {7'h0, e.rco});
      end
      if (sb2.size() > 0) begin
        e = sb2.pop_front();
        chk({e.name, ".q"}, q2, e.q);
        chk({e.name, ".rco"}, {7'h0, rco2}, {7'h0, e.rco});
      end
    end
  end

  initial begin
    logic       ren;
    logic [1:0] rm;
    logic [7:0] rd, nq;
    logic       nr;

    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset mid-count
    step1("ld9", 1, MODO_LOAD, 4'd9, 4'd9, 0);
    @(negedge clk);
    en1 = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst.q", {4'h0, q1}, 8'h00);
    chk("async_rst.rco", {7'h0, rco1}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step1("hold0", 0, MODO_UP1, 4'd7, 4'd0, 0);

    step1("ld14", 1, MODO_LOAD, 4'd14, 4'd14, 0);
    step1("up1_a", 1, MODO_UP1, 4'd0, 4'd15, 0);
    step1("up1_b", 1, MODO_UP1, 4'd0, 4'd0, 1);
    step1("up1_c", 1, MODO_UP1, 4'd0, 4'd1, 0);

    step1("ld1", 1, MODO_LOAD, 4'd1, 4'd1, 0);
    step1("dn1_a", 1, MODO_DN1, 4'd0, 4'd0, 0);
    step1("dn1_b", 1, MODO_DN1, 4'd0, 4'd15, 1);
    step1("dn1_c", 1, MODO_DN1, 4'd0, 4'd14, 0);

    step1("ld12", 1, MODO_LOAD, 4'd12, 4'd12, 0);
    step1("up3_a", 1, MODO_UP3, 4'd0, 4'd15, 0);
    step1("up3_b", 1, MODO_UP3, 4'd0, 4'd2, 1);
    step1("up3_c", 1, MODO_UP3, 4'd0, 4'd5, 0);
    step1("ld13", 1, MODO_LOAD, 4'd13, 4'd13, 0);
    step1("up3_d", 1, MODO_UP3, 4'd0, 4'd0, 1);

    step1("ld15a", 1, MODO_LOAD, 4'd15, 4'd15, 0);
    step1("ld15b", 1, MODO_LOAD, 4'd15, 4'd15, 0);
    step1("hold_ld", 0, MODO_LOAD, 4'd3, 4'd15, 0);
    step1("hold_x", 0, 2'bxx, 4'd3, 4'd15, 0);
    step1("ld0", 1, MODO_LOAD, 4'd0, 4'd0, 0);
    step1("dn_b2b", 1, MODO_DN1, 4'd0, 4'd15, 1);
    step1("up_b2b", 1, MODO_UP1, 4'd0, 4'd0, 1);

    // Cascade, 8-bit
    step2("c_ld0f", 1, MODO_LOAD, 8'h0F, 8'h0F, 0);
    step2("c_up1", 1, MODO_UP1, 8'h00, 8'h10, 0);
    step2("c_ldfe", 1, MODO_LOAD, 8'hFE, 8'hFE, 0);
    step2("c_up3", 1, MODO_UP3, 8'h00, 8'h01, 1);
    step2("c_ld00", 1, MODO_LOAD, 8'h00, 8'h00, 0);
    step2("c_dn1", 1, MODO_DN1, 8'h00, 8'hFF, 1);
    step2("c_up1w", 1, MODO_UP1, 8'h00, 8'h00, 1);
    step2("c_ld10", 1, MODO_LOAD, 8'h10, 8'h10, 0);
    step2("c_dn1b", 1, MODO_DN1, 8'h00, 8'h0F, 0);

    for (int i = 0; i < 20; i++) begin
      ren = 1'($urandom_range(0, 3) != 0);
      rm  = 2'($urandom_range(0, 3));
      rd  = 8'($urandom_range(0, 255));
      if (i % 5 == 0) rd = 8'hFD;
      model(ren, rm, rd, cur2, nq, nr);
      step2("c_rand", ren, rm, rd, nq, nr);
    end

    repeat (3) @(negedge clk);
    chk("sb1_drained", 8'(sb1.size()), 8'h00);
    chk("sb2_drained", 8'(sb2.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
